cp0_core: RTL

- Parametrised successor to the single-width CP0 register block. Provides Count/Compare timer with prescaler, configurable hardware-interrupt width, masked interrupt request generation, EXL-aware exception and ERET commit, and redirect-target generation.
- Sits beside the MEM/WB boundary. The exception unit drives the commit inputs. The pipeline consumes int_req_o, flush_o and target_o.

---
 rtl/cp0_core.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/cp0_core.sv
// CP0 register block: Count/Compare timer, masked interrupt request, exception/ERET commit and redirect.
// Define CP0_EBASE_EN to add the EBase register at (15,1) and use it for the non-BEV exception vector.
module cp0_core #(
    parameter int unsigned NUM_HW_INT     = 6,
    parameter int unsigned COUNT_DIV      = 2,
    parameter logic [31:0] EXC_VECTOR_BEV = 32'hBFC00380,
    parameter logic [31:0] PRID_VAL       = 32'h004C0102
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [2:0]            wsel_i,
    input  logic [31:0]           wdata_i,
    input  logic [4:0]            raddr_i,
    input  logic [2:0]            rsel_i,
    output logic [31:0]           rdata_o,
    input  logic [NUM_HW_INT-1:0] hw_int_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_code_i,
    input  logic [31:0]           exc_pc_i,
    input  logic                  exc_bd_i,
    input  logic [31:0]           exc_badvaddr_i,
    input  logic                  eret_i,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic                  int_req_o,
    output logic                  timer_int_o,
    output logic                  flush_o,
    output logic [31:0]           target_o
);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned PW     = 4;
    localparam int unsigned HW_MAX = 6;
    localparam int unsigned KEY_W  = 8;

    localparam logic [PW-1:0]    PRESC_LAST = PW'(COUNT_DIV - 1);
    localparam logic [KEY_W-1:0] A_BADV     = {5'd8,  3'd0};
    localparam logic [KEY_W-1:0] A_COUNT    = {5'd9,  3'd0};
    localparam logic [KEY_W-1:0] A_COMPARE  = {5'd11, 3'd0};
    localparam logic [KEY_W-1:0] A_STATUS   = {5'd12, 3'd0};
    localparam logic [KEY_W-1:0] A_CAUSE    = {5'd13, 3'd0};
    localparam logic [KEY_W-1:0] A_EPC      = {5'd14, 3'd0};
    localparam logic [KEY_W-1:0] A_PRID     = {5'd15, 3'd0};
`ifdef CP0_EBASE_EN
    localparam logic [KEY_W-1:0] A_EBASE    = {5'd15, 3'd1};
`endif

    logic [XLEN-1:0]   count_q, compare_q, badvaddr_q, epc_q, target_q;
    logic [PW-1:0]     presc_q;
    logic              bev_q, exl_q, ie_q;
    logic [7:0]        im_q;
    logic              bd_q, ti_q, flush_q;
    logic [1:0]        ip_sw_q;
    logic [HW_MAX-1:0] ip_hw_q;
    logic [4:0]        exc_code_q;
`ifdef CP0_EBASE_EN
    logic [17:0]       ebase_q;
    logic [XLEN-1:0]   ebase_w;
`endif

    logic [HW_MAX-1:0] hw_ext;
    logic              take_exc, take_eret, mtc0;
    logic [KEY_W-1:0]  wkey, rkey;
    logic              wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic              presc_wrap, count_match;
    logic [7:0]        ip;
    logic [XLEN-1:0]   status_w, cause_w, exc_vector;

    // Commit priority: exception, then ERET, then MTC0.
    assign take_exc  = exc_valid_i;
    assign take_eret = eret_i & ~exc_valid_i;
    assign mtc0      = we_i & ~exc_valid_i & ~eret_i;

    assign wkey       = {waddr_i, wsel_i};
    assign rkey       = {raddr_i, rsel_i};
    assign wr_count   = mtc0 && (wkey == A_COUNT);
    assign wr_compare = mtc0 && (wkey == A_COMPARE);
    assign wr_status  = mtc0 && (wkey == A_STATUS);
    assign wr_cause   = mtc0 && (wkey == A_CAUSE);
    assign wr_epc     = mtc0 && (wkey == A_EPC);

    assign hw_ext      = HW_MAX'(hw_int_i);
    assign presc_wrap  = (presc_q == PRESC_LAST);
    assign count_match = (count_q == compare_q);

    // IP7 is shared between the top hardware line and the timer.
    assign ip       = {ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q};
    assign status_w = {9'b0, bev_q, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_w  = {bd_q, ti_q, 14'b0, ip, 1'b0, exc_code_q, 2'b0};

`ifdef CP0_EBASE_EN
    assign ebase_w    = {2'b10, ebase_q, 12'b0};
    assign exc_vector = bev_q ? EXC_VECTOR_BEV : ebase_w + 32'h0000_0180;
`else
    assign exc_vector = bev_q ? EXC_VECTOR_BEV : 32'h8000_0180;
`endif

    assign status_o    = status_w;
    assign cause_o     = cause_w;
    assign epc_o       = epc_q;
    assign timer_int_o = ti_q;
    assign flush_o     = flush_q;
    assign target_o    = target_q;
    assign int_req_o   = ie_q & ~exl_q & (|(im_q & ip));

    // Read mux shows current register state, no write bypass.
    always_comb begin
        rdata_o = '0;
        unique case (rkey)
            A_BADV:    rdata_o = badvaddr_q;
            A_COUNT:   rdata_o = count_q;
            A_COMPARE: rdata_o = compare_q;
            A_STATUS:  rdata_o = status_w;
            A_CAUSE:   rdata_o = cause_w;
            A_EPC:     rdata_o = epc_q;
            A_PRID:    rdata_o = PRID_VAL;
`ifdef CP0_EBASE_EN
            A_EBASE:   rdata_o = ebase_w;
`endif
            default:   rdata_o = '0;
        endcase
    end

    // Timer, interrupt sampling and software-visible register updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            compare_q  <= '0;
            badvaddr_q <= '0;
            epc_q      <= '0;
            target_q   <= '0;
            presc_q    <= '0;
            bev_q      <= 1'b1;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            flush_q    <= 1'b0;
            ip_sw_q    <= '0;
            ip_hw_q    <= '0;
            exc_code_q <= '0;
`ifdef CP0_EBASE_EN
            ebase_q    <= '0;
`endif
        end else begin
            ip_hw_q <= hw_ext;
            flush_q <= 1'b0;

            if (wr_count) begin
                count_q <= wdata_i;
                presc_q <= '0;
            end else if (presc_wrap) begin
                count_q <= count_q + 32'd1;
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + PW'(1);
            end

            // A Compare write acknowledges the timer even on a coincident match.
            if (wr_compare) begin
                compare_q <= wdata_i;
                ti_q      <= 1'b0;
            end else if (count_match) begin
                ti_q <= 1'b1;
            end

            if (wr_status) begin
                bev_q <= wdata_i[22];
                im_q  <= wdata_i[15:8];
                exl_q <= wdata_i[1];
                ie_q  <= wdata_i[0];
            end
            if (wr_cause) ip_sw_q <= wdata_i[9:8];
            if (wr_epc)   epc_q   <= wdata_i;
`ifdef CP0_EBASE_EN
            if (mtc0 && (wkey == A_EBASE)) ebase_q <= wdata_i[29:12];
`endif

            if (take_exc) begin
                // Nested exceptions keep the original return address.
                if (!exl_q) begin
                    epc_q <= exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
                    bd_q  <= exc_bd_i;
                end
                exl_q      <= 1'b1;
                exc_code_q <= exc_code_i;
                if ((exc_code_i == 5'd4) || (exc_code_i == 5'd5)) badvaddr_q <= exc_badvaddr_i;
                flush_q  <= 1'b1;
                target_q <= exc_vector;
            end else if (take_eret) begin
                exl_q    <= 1'b0;
                flush_q  <= 1'b1;
                target_q <= epc_q;
            end
        end
    end

endmodule
